// File: rtl/ama_riscv_spec_tracker_pkg.sv
// -----------------------------------------------------------------------------
// ama_riscv_spec_tracker_pkg
// Shared definitions for the branch speculation tracker:
//   - branch_t      : branch direction encoding (B_T = taken, B_NT = not taken)
//   - spec_entry_t  : one tracked speculation {pc, pred} for the default PC width
//   - spec_state_t  : tracker occupancy state (IDLE = empty, SPEC = non-empty)
//   - pred_correct  : helper comparing a prediction with the actual outcome
// -----------------------------------------------------------------------------
package ama_riscv_spec_tracker_pkg;

  typedef enum logic {
    B_NT = 1'b0,
    B_T  = 1'b1
  } branch_t;

  localparam int unsigned SPEC_PC_W = 32;

  // Layout matches the flat {pc, pred} word stored in the circular buffer:
  // pred sits in bit 0, pc above it.
  typedef struct packed {
    logic [SPEC_PC_W-1:0] pc;
    branch_t              pred;
  } spec_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SPEC = 1'b1
  } spec_state_t;

  function automatic logic pred_correct(input branch_t pred, input branch_t outcome);
    return pred == outcome;
  endfunction

endpackage

// File: rtl/ama_riscv_circ_buf.sv
// -----------------------------------------------------------------------------
// ama_riscv_circ_buf
// Generic circular buffer with a combinational head read.
// Pointers carry an extra wrap bit: equal pointers mean empty, equal indices
// with differing wrap bits mean full.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears pointers and storage)
//   i_push       : write i_data at the tail
//   i_pop        : drop the head entry
//   i_clear      : drop every entry (pointers back to 0); overrides push/pop
//   i_data       : data to push
//   o_head       : oldest entry (undefined content when empty)
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_count      : occupancy, 0..DEPTH
// The owner must not push while full unless it pops in the same cycle; the
// written slot is then the one being popped, which is safe because the head
// is read combinationally before the edge.
// -----------------------------------------------------------------------------
module ama_riscv_circ_buf #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 33,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0] w_we;
  logic [AW-1:0]  w_wr_idx;
  logic [AW-1:0]  w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // One-hot write enable per slot; a clear discards the same-cycle push.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = i_push && !i_clear && (w_wr_idx == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= i_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_head  = r_mem[w_rd_idx];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ama_riscv_spec_tracker.sv
// -----------------------------------------------------------------------------
// ama_riscv_spec_tracker
// Tracks up to SPEC_DEPTH predicted, unresolved conditional branches in program
// order. Each execute-stage resolution is checked against the oldest entry;
// a correct prediction retires it, a wrong one flushes everything and exposes
// the checkpoint PC for the fetch redirect.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears all state)
//   i_enter          : predicted branch in decode (not blocked by a stall)
//   i_pc_dec         : PC of the decode branch
//   i_pred_dec       : its prediction (B_T / B_NT)
//   i_resolve_valid  : branch in execute, no hazard
//   i_pc_exe         : PC of the execute instruction
//   i_resolution     : actual outcome (B_T / B_NT)
//   o_full, o_empty  : occupancy flags
//   o_count          : occupancy
//   o_bp_hit         : head resolved, prediction correct (combinational)
//   o_spec_wrong     : head resolved, prediction wrong; flush request (combinational)
//   o_pc_cp          : head PC (checkpoint), 0 when empty
//   o_hit_cnt        : saturating count of correct predictions
//   o_miss_cnt       : saturating count of mispredictions
//   o_err_overflow   : sticky; an enter was dropped because the tracker was full
// -----------------------------------------------------------------------------
module ama_riscv_spec_tracker
  import ama_riscv_spec_tracker_pkg::*;
#(
  parameter  int unsigned SPEC_DEPTH = 4,
  parameter  int unsigned PC_W       = 32,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned CW         = $clog2(SPEC_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enter,
  input  logic [PC_W-1:0]  i_pc_dec,
  input  branch_t          i_pred_dec,
  input  logic             i_resolve_valid,
  input  logic [PC_W-1:0]  i_pc_exe,
  input  branch_t          i_resolution,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_bp_hit,
  output logic             o_spec_wrong,
  output logic [PC_W-1:0]  o_pc_cp,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt,
  output logic             o_err_overflow
);

  localparam int unsigned EW = PC_W + 1;

  spec_state_t      r_state;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_err_overflow;

  logic [EW-1:0]    w_head;
  logic [EW-1:0]    w_push_data;
  logic [PC_W-1:0]  w_head_pc;
  branch_t          w_head_pred;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_match;
  logic             w_hit;
  logic             w_wrong;
  logic             w_push;
  logic             w_drop;

  // Entries are stored flat as {pc, pred}, same layout as spec_entry_t.
  assign w_push_data = {i_pc_dec, i_pred_dec};
  assign w_head_pc   = w_head[EW-1:1];
  assign w_head_pred = branch_t'(w_head[0]);

  ama_riscv_circ_buf #(
    .DEPTH (SPEC_DEPTH),
    .W     (EW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_hit),
    .i_clear (w_wrong),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // PC 0 never matches: it marks a bubble / non-branch in execute.
  assign w_match = i_resolve_valid && (r_state == ST_SPEC) && !w_empty
                   && (w_head_pc == i_pc_exe) && (i_pc_exe != '0);
  assign w_hit   = w_match && pred_correct(w_head_pred, i_resolution);
  assign w_wrong = w_match && !w_hit;

  // A flush kills the decode instruction (it is on the wrong path), so the
  // push is neither accepted nor counted as an overflow. A full tracker still
  // accepts a push when the head retires in the same cycle.
  assign w_push = i_enter && !w_wrong && (!w_full || w_hit);
  assign w_drop = i_enter && !w_wrong && w_full && !w_hit;

  // State mirrors occupancy: SPEC whenever at least one branch is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state <= ST_SPEC;
          end
        end
        ST_SPEC: begin
          if (w_wrong) begin
            r_state <= ST_IDLE;
          end else if (w_hit && !w_push && (w_count == CW'(1))) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Perf counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt      <= '0;
      r_miss_cnt     <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_hit && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (w_wrong && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_drop) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_count        = w_count;
  assign o_bp_hit       = w_hit;
  assign o_spec_wrong   = w_wrong;
  assign o_pc_cp        = w_empty ? '0 : w_head_pc;
  assign o_hit_cnt      = r_hit_cnt;
  assign o_miss_cnt     = r_miss_cnt;
  assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ama_riscv_spec_tracker.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_spec_tracker
// Directed bench for the speculation tracker. A queue-based reference model
// tracks the in-flight branches; expected same-cycle results are queued when a
// cycle is driven and popped when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_ama_riscv_spec_tracker;
  import ama_riscv_spec_tracker_pkg::*;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int CNTW  = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            enter;
  logic [PCW-1:0]  pc_dec;
  branch_t         pred_dec;
  logic            resolve_valid;
  logic [PCW-1:0]  pc_exe;
  branch_t         resolution;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            bp_hit;
  logic            spec_wrong;
  logic [PCW-1:0]  pc_cp;
  logic [CNTW-1:0] hit_cnt;
  logic [CNTW-1:0] miss_cnt;
  logic            err_overflow;

  always #5 clk = ~clk;

  ama_riscv_spec_tracker #(
    .SPEC_DEPTH (DEPTH),
    .PC_W       (PCW),
    .CNT_W      (CNTW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_enter         (enter),
    .i_pc_dec        (pc_dec),
    .i_pred_dec      (pred_dec),
    .i_resolve_valid (resolve_valid),
    .i_pc_exe        (pc_exe),
    .i_resolution    (resolution),
    .o_full          (full),
    .o_empty         (empty),
    .o_count         (count),
    .o_bp_hit        (bp_hit),
    .o_spec_wrong    (spec_wrong),
    .o_pc_cp         (pc_cp),
    .o_hit_cnt       (hit_cnt),
    .o_miss_cnt      (miss_cnt),
    .o_err_overflow  (err_overflow)
  );

  typedef struct {
    logic           hit;
    logic           wrong;
    logic [PCW-1:0] cp;
  } exp_t;

  // Reference model: in-flight entries {pc, pred}, counters, sticky flag.
  logic [PCW:0] mq[$];
  exp_t         sbq[$];
  int           exp_hit;
  int           exp_miss;
  logic         exp_ovf;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".empty"},    64'(empty),        64'(mq.size() == 0));
    chk({tag, ".full"},     64'(full),         64'(mq.size() == DEPTH));
    chk({tag, ".count"},    64'(count),        64'(mq.size()));
    chk({tag, ".hit_cnt"},  64'(hit_cnt),      64'(exp_hit));
    chk({tag, ".miss_cnt"}, 64'(miss_cnt),     64'(exp_miss));
    chk({tag, ".ovf"},      64'(err_overflow), 64'(exp_ovf));
  endtask

  // One clock of stimulus: drive, check same-cycle outputs, update model,
  // then check registered state after the edge.
  task automatic cycle(input string tag, input logic en, input logic [PCW-1:0] pcd,
                       input branch_t pd, input logic v, input logic [PCW-1:0] pce,
                       input branch_t res);
    exp_t         e;
    logic [PCW:0] head;
    logic         match;
    logic         hit;
    logic         wrong;
    enter         = en;
    pc_dec        = pcd;
    pred_dec      = pd;
    resolve_valid = v;
    pc_exe        = pce;
    resolution    = res;
    head  = (mq.size() > 0) ? mq[0] : '0;
    match = v && (mq.size() > 0) && (head[PCW:1] == pce) && (pce != '0);
    hit   = match && (head[0] == res);
    wrong = match && !hit;
    e.hit   = hit;
    e.wrong = wrong;
    e.cp    = head[PCW:1];
    sbq.push_back(e);
    @(negedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".bp_hit"},     64'(bp_hit),     64'(e.hit));
    chk({tag, ".spec_wrong"}, 64'(spec_wrong), 64'(e.wrong));
    chk({tag, ".pc_cp"},      64'(pc_cp),      64'(e.cp));
    if (wrong) begin
      mq.delete();
      exp_miss = (exp_miss == CMAX) ? CMAX : exp_miss + 1;
    end else begin
      if (hit) begin
        void'(mq.pop_front());
        exp_hit = (exp_hit == CMAX) ? CMAX : exp_hit + 1;
      end
      if (en) begin
        if (mq.size() < DEPTH) mq.push_back({pcd, pd});
        else                   exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    enter         = 1'b0;
    resolve_valid = 1'b0;
    check_state(tag);
    $display("txn %s en=%0d pc_dec=%h rv=%0d pc_exe=%h bp_hit=%0d spec_wrong=%0d count=%0d hit_cnt=%0d miss_cnt=%0d ovf=%0d",
             tag, en, pcd, v, pce, e.hit, e.wrong, count, hit_cnt, miss_cnt, err_overflow);
  endtask

  task automatic push(input string tag, input logic [PCW-1:0] pcd, input branch_t pd);
    cycle(tag, 1'b1, pcd, pd, 1'b0, '0, B_NT);
  endtask

  task automatic resolve(input string tag, input logic [PCW-1:0] pce, input branch_t res);
    cycle(tag, 1'b0, '0, B_NT, 1'b1, pce, res);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_hit  = 0;
    exp_miss = 0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    enter         = 1'b0;
    pc_dec        = '0;
    pred_dec      = B_NT;
    resolve_valid = 1'b0;
    pc_exe        = '0;
    resolution    = B_NT;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset");
    chk("reset.bp_hit",     64'(bp_hit),     64'(0));
    chk("reset.spec_wrong", 64'(spec_wrong), 64'(0));
    chk("reset.pc_cp",      64'(pc_cp),      64'(0));
    $display("txn reset empty=%0d count=%0d", empty, count);

    // Single correct prediction retires the entry.
    push("push100", 32'h100, B_T);
    resolve("hit100", 32'h100, B_T);

    // Misprediction on the head flushes all three entries.
    push("push100b", 32'h100, B_T);
    push("push108", 32'h108, B_NT);
    push("push110", 32'h110, B_T);
    resolve("miss100", 32'h100, B_NT);

    // Fill, overflow, then full + simultaneous hit accepts the push.
    push("fill0", 32'h180, B_T);
    push("fill1", 32'h184, B_T);
    push("fill2", 32'h188, B_T);
    push("fill3", 32'h18c, B_T);
    push("ovf200", 32'h200, B_T);
    cycle("full_hit_push", 1'b1, 32'h204, B_T, 1'b1, 32'h180, B_T);

    // Flush beats a same-cycle enter; 0x300 must not be tracked.
    cycle("flush_enter", 1'b1, 32'h300, B_T, 1'b1, 32'h184, B_NT);
    resolve("no300", 32'h300, B_T);

    // Pointer wrap-around with alternating predictions.
    for (int i = 0; i < 10; i++) begin
      push("wrap_push", 32'h1000 + 32'(i * 4), (i % 2) ? B_NT : B_T);
      resolve("wrap_hit", 32'h1000 + 32'(i * 4), (i % 2) ? B_NT : B_T);
    end

    // Drive hit_cnt up to all-ones minus 1, then two more hits.
    while (exp_hit < CMAX - 1) begin
      push("sat_push", 32'h2000, B_T);
      resolve("sat_hit", 32'h2000, B_T);
    end
    for (int i = 0; i < 2; i++) begin
      push("sat_push2", 32'h2004, B_NT);
      resolve("sat_hit2", 32'h2004, B_NT);
    end
    chk("hit_cnt_saturated", 64'(hit_cnt), 64'(CMAX));

    // PC 0 and non-matching PCs never resolve the head.
    push("push_pc0", 32'h0, B_T);
    resolve("res_pc0", 32'h0, B_T);
    resolve("res_nomatch", 32'h999, B_NT);
    push("push40", 32'h40, B_T);
    push("push44", 32'h44, B_NT);

    // Reset with three entries held, enter active: everything clears.
    rst           = 1'b1;
    enter         = 1'b1;
    pc_dec        = 32'h777;
    pred_dec      = B_T;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    enter = 1'b0;
    model_reset();
    check_state("rst_mid");
    chk("rst_mid.bp_hit",     64'(bp_hit),     64'(0));
    chk("rst_mid.spec_wrong", 64'(spec_wrong), 64'(0));
    chk("rst_mid.pc_cp",      64'(pc_cp),      64'(0));
    $display("txn rst_mid empty=%0d count=%0d", empty, count);
    resolve("no777", 32'h777, B_T);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
